pipeline_run_ctrl: RTL and testbench

//  Parametrised run/stall controller for the 5-stage DLX pipeline. It replaces the single global enable with a debug-capable FSM.

---
 rtl/pipeline_run_ctrl_pkg.sv | 25 ++
 rtl/pipeline_run_ctrl_bp_match.sv | 44 ++++
 rtl/pipeline_run_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared state/command encodings and sizing helpers for the pipeline run/stall controller.
// The UART debug command decoder imports the same encodings.
package pipeline_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } run_state_e;

  typedef enum logic [1:0] {
    OP_STOP  = 2'b00,
    OP_RUN   = 2'b01,
    OP_STEP  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_run_ctrl_bp_match.sv
// PC breakpoint slots: one address/enable register pair per slot plus an equality comparator.
// Slot writes land on the clock edge, so a write never affects the match in its own cycle.
module pipeline_run_ctrl_bp_match
  import pipeline_run_ctrl_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int NUM_BP = 2,
  parameter int IDX_W  = min1_clog2(NUM_BP)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [PC_W-1:0]   i_addr,
  input  logic              i_en,
  input  logic [PC_W-1:0]   i_pc,
  output logic [NUM_BP-1:0] o_match
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BP; gi++) begin : g_slot
      logic            r_en;
      logic [PC_W-1:0] r_addr;
      logic            w_sel;

      // Out-of-range indices (non power-of-two NUM_BP) select no slot.
      assign w_sel = i_wr & (i_idx == IDX_W'(gi));

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_en   <= 1'b0;
          r_addr <= '0;
        end else if (w_sel) begin
          r_en   <= i_en;
          r_addr <= i_addr;
        end
      end

      assign o_match[gi] = r_en & (r_addr == i_pc);
    end
  endgenerate

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/stall controller for the 5-stage DLX pipeline: run, single-step, PC breakpoints,
// drain-on-HALT, plus load-use stall and branch-flush gating of the PC and IF/ID latches.
module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter int PC_W         = 10,
  parameter int CNT_W        = 32,
  parameter int NUM_BP       = 2,
  parameter int DRAIN_CYCLES = 3,
  localparam int IDX_W       = min1_clog2(NUM_BP)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic              i_bp_wr,
  input  logic [IDX_W-1:0]  i_bp_idx,
  input  logic [PC_W-1:0]   i_bp_addr,
  input  logic              i_bp_en,
  input  logic [PC_W-1:0]   i_pc_if,
  input  logic              i_halt_id,
  input  logic              i_branch_taken,
  input  logic              i_mem_read_ex,
  input  logic [4:0]        i_rt_ex,
  input  logic [4:0]        i_rs_id,
  input  logic [4:0]        i_rt_id,
  output logic              o_pipe_enable,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush,
  output logic              o_ctrl_bubble,
  output logic [2:0]        o_run_state,
  output logic              o_halted,
  output logic [NUM_BP-1:0] o_bp_hit,
  output logic [CNT_W-1:0]  o_cycle_count
);

  localparam int DW = min1_clog2(DRAIN_CYCLES);

  run_state_e        r_state;
  run_state_e        w_state_next;
  logic [DW-1:0]     r_drain_cnt;
  logic [DW-1:0]     w_drain_next;
  logic              r_skip_bp;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [NUM_BP-1:0] r_bp_hit;

  logic [NUM_BP-1:0] w_match;
  logic [NUM_BP-1:0] w_new_hit;
  logic              w_bp_active;
  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_clear;
  logic              w_start;
  logic              w_load_use;
  logic              w_stall;
  logic              w_pipe_enable;

  pipeline_run_ctrl_bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP),
    .IDX_W  (IDX_W)
  ) u_bp_match (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (i_bp_wr),
    .i_idx   (i_bp_idx),
    .i_addr  (i_bp_addr),
    .i_en    (i_bp_en),
    .i_pc    (i_pc_if),
    .o_match (w_match)
  );

  // skip_bp lets a resume step past the breakpoint it stopped on.
  assign w_bp_active = (|w_match) & ~r_skip_bp;
  assign w_cmd_ready = (r_state != ST_DRAIN);
  assign w_accept    = i_cmd_valid & w_cmd_ready;
  assign w_clear     = w_accept & (i_cmd_op == OP_CLEAR);
  assign w_load_use  = i_mem_read_ex & (i_rt_ex != 5'd0) &
                       ((i_rt_ex == i_rs_id) | (i_rt_ex == i_rt_id));
  assign w_new_hit   = ((r_state == ST_RUN) && w_bp_active) ? w_match : '0;

  always_comb begin
    w_state_next  = r_state;
    w_drain_next  = r_drain_cnt;
    w_pipe_enable = 1'b0;
    w_start       = 1'b0;
    w_stall       = 1'b0;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_if_id_flush = 1'b0;
    o_ctrl_bubble = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept && (i_cmd_op == OP_RUN)) begin
          w_state_next = ST_RUN;
          w_start      = 1'b1;
        end else if (w_accept && (i_cmd_op == OP_STEP)) begin
          w_state_next = ST_STEP;
          w_start      = 1'b1;
        end
      end
      ST_RUN: begin
        // Breakpoint freezes in the same cycle and outranks both HALT and STOP.
        if (w_bp_active) begin
          w_state_next = ST_IDLE;
        end else begin
          w_pipe_enable = 1'b1;
          if (i_halt_id) begin
            w_state_next = ST_DRAIN;
            w_drain_next = DW'(DRAIN_CYCLES - 1);
          end else if (w_accept && (i_cmd_op == OP_STOP)) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_STEP: begin
        w_pipe_enable = 1'b1;
        if (i_halt_id) begin
          w_state_next = ST_DRAIN;
          w_drain_next = DW'(DRAIN_CYCLES - 1);
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        w_pipe_enable = 1'b1;
        if (r_drain_cnt == '0) begin
          w_state_next = ST_HALTED;
        end else begin
          w_drain_next = r_drain_cnt - DW'(1);
        end
      end
      ST_HALTED: begin
        if (w_clear) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_stall       = w_pipe_enable & w_load_use;
    o_if_id_flush = w_pipe_enable & i_branch_taken & ~w_stall;
    if (w_pipe_enable && !w_stall && (r_state != ST_DRAIN)) begin
      o_pc_write    = 1'b1;
      o_if_id_write = 1'b1;
    end
    // During DRAIN the HALT sits frozen in IF/ID, so ID keeps issuing bubbles.
    o_ctrl_bubble = w_stall |
                    (w_pipe_enable & i_halt_id & ((r_state == ST_RUN) | (r_state == ST_STEP))) |
                    (r_state == ST_DRAIN);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_drain_cnt   <= '0;
      r_skip_bp     <= 1'b0;
      r_cycle_count <= '0;
      r_bp_hit      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
      if (w_start) begin
        r_skip_bp <= 1'b1;
      end else if (w_pipe_enable) begin
        r_skip_bp <= 1'b0;
      end
      if (w_clear) begin
        r_cycle_count <= '0;
      end else if (w_pipe_enable && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      r_bp_hit <= (w_clear ? '0 : r_bp_hit) | w_new_hit;
    end
  end

  assign o_cmd_ready   = w_cmd_ready;
  assign o_pipe_enable = w_pipe_enable;
  assign o_run_state   = r_state;
  assign o_halted      = (r_state == ST_HALTED);
  assign o_bp_hit      = r_bp_hit;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl: directed scenarios plus randomized cycles checked
// against a behavioural model of the run/stall rules.
module tb_pipeline_run_ctrl;
  import pipeline_run_ctrl_pkg::*;

  localparam int CNT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       bp_wr;
  logic [0:0] bp_idx;
  logic [9:0] bp_addr;
  logic       bp_en;
  logic [9:0] pc_if;
  logic       halt_id, branch_taken, mem_read_ex;
  logic [4:0] rt_ex, rs_id, rt_id;
  logic       pipe_enable, pc_write, if_id_write, if_id_flush, ctrl_bubble;
  logic [2:0] run_state;
  logic       halted;
  logic [1:0] bp_hit;
  logic [3:0] cycle_count;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_run_ctrl #(.PC_W(10), .CNT_W(4), .NUM_BP(2), .DRAIN_CYCLES(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_bp_wr(bp_wr), .i_bp_idx(bp_idx), .i_bp_addr(bp_addr),
    .i_bp_en(bp_en), .i_pc_if(pc_if), .i_halt_id(halt_id), .i_branch_taken(branch_taken),
    .i_mem_read_ex(mem_read_ex), .i_rt_ex(rt_ex), .i_rs_id(rs_id), .i_rt_id(rt_id),
    .o_pipe_enable(pipe_enable), .o_pc_write(pc_write), .o_if_id_write(if_id_write),
    .o_if_id_flush(if_id_flush), .o_ctrl_bubble(ctrl_bubble), .o_run_state(run_state),
    .o_halted(halted), .o_bp_hit(bp_hit), .o_cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Behavioural model
  run_state_e m_state;
  logic       m_skip;
  int         m_drain_left;
  int         m_count;
  logic [1:0] m_hit;
  logic       m_slot_en [2];
  logic [9:0] m_slot_addr [2];

  function automatic logic [1:0] m_match_vec();
    logic [1:0] v;
    for (int s = 0; s < 2; s++) v[s] = m_slot_en[s] && (m_slot_addr[s] == pc_if);
    return v;
  endfunction
  function automatic logic m_freeze();
    return (m_state == ST_RUN) && (m_match_vec() != 2'b00) && !m_skip;
  endfunction
  function automatic logic m_pe();
    return ((m_state == ST_RUN) && !m_freeze()) || (m_state == ST_STEP) || (m_state == ST_DRAIN);
  endfunction
  function automatic logic m_stall();
    return m_pe() && mem_read_ex && (rt_ex != 0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
  endfunction
  function automatic logic m_pcw();
    return m_pe() && !m_stall() && (m_state != ST_DRAIN);
  endfunction
  function automatic logic m_flush();
    return m_pe() && branch_taken && !m_stall();
  endfunction
  function automatic logic m_bubble();
    return m_stall() || (m_pe() && halt_id);
  endfunction

  task automatic m_reset();
    m_state = ST_IDLE; m_skip = 1'b0; m_drain_left = 0; m_count = 0; m_hit = 2'b00;
    for (int s = 0; s < 2; s++) begin m_slot_en[s] = 1'b0; m_slot_addr[s] = '0; end
  endtask

  task automatic model_update();
    logic pe, acc, clr, frz;
    logic [1:0] mv;
    run_state_e nxt;
    pe = m_pe(); acc = cmd_valid && (m_state != ST_DRAIN);
    clr = acc && (cmd_op == OP_CLEAR); frz = m_freeze(); mv = m_match_vec();
    nxt = m_state;
    case (m_state)
      ST_IDLE: if (acc && (cmd_op == OP_RUN)) nxt = ST_RUN;
               else if (acc && (cmd_op == OP_STEP)) nxt = ST_STEP;
      ST_RUN: begin
        if (frz) nxt = ST_IDLE;
        else if (halt_id) begin nxt = ST_DRAIN; m_drain_left = 3; end
        else if (acc && (cmd_op == OP_STOP)) nxt = ST_IDLE;
      end
      ST_STEP: begin
        if (halt_id) begin nxt = ST_DRAIN; m_drain_left = 3; end
        else nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        m_drain_left--;
        if (m_drain_left == 0) nxt = ST_HALTED;
      end
      default: if (clr) nxt = ST_IDLE;
    endcase
    if (clr) m_count = 0;
    else if (pe && (m_count < CNT_MAX)) m_count++;
    m_hit = (clr ? 2'b00 : m_hit) | (frz ? mv : 2'b00);
    if ((m_state == ST_IDLE) && acc && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) m_skip = 1'b1;
    else if (pe) m_skip = 1'b0;
    if (bp_wr) begin m_slot_en[bp_idx] = bp_en; m_slot_addr[bp_idx] = bp_addr; end
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_op = 2'b00; bp_wr = 0; bp_idx = '0; bp_addr = '0; bp_en = 0;
    pc_if = 10'h3FF; halt_id = 0; branch_taken = 0; mem_read_ex = 0;
    rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    cmd_valid = 1'b1; cmd_op = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; branch_taken = 1; mem_read_ex = 1; rt_ex = 5'd2; rs_id = 5'd2;
    m_reset();
    #3;
    n_checks++; if (run_state !== 3'(ST_IDLE)) $display("FAIL reset_state: got %0d expected %0d", run_state, ST_IDLE); else n_pass++;
    n_checks++; if (pipe_enable !== 1'b0) $display("FAIL reset_pe: got %b expected 0", pipe_enable); else n_pass++;
    n_checks++; if ({pc_write, if_id_write, if_id_flush, ctrl_bubble} !== 4'b0000) $display("FAIL reset_enables: got %b expected 0000", {pc_write, if_id_write, if_id_flush, ctrl_bubble}); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready); else n_pass++;
    n_checks++; if ({cycle_count, bp_hit, halted} !== 7'd0) $display("FAIL reset_regs: got %0h expected 0", {cycle_count, bp_hit, halted}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_run_stop();
    send_cmd(OP_RUN);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin cmd_valid = 1; cmd_op = OP_STOP; end
      #2;
      n_checks++; if (pipe_enable !== 1'b1 || pc_write !== 1'b1) $display("FAIL run_enable: cycle %0d got pe=%b pcw=%b expected 1 1", i, pipe_enable, pc_write); else n_pass++;
      tick();
    end
    cmd_valid = 0;
    #2;
    n_checks++; if (run_state !== 3'(ST_IDLE)) $display("FAIL stop_state: got %0d expected %0d", run_state, ST_IDLE); else n_pass++;
    n_checks++; if (pipe_enable !== 1'b0) $display("FAIL stop_pe: got %b expected 0", pipe_enable); else n_pass++;
    n_checks++; if (cycle_count !== 4'd10) $display("FAIL stop_count: got %0d expected 10", cycle_count); else n_pass++;
  endtask

  task automatic test_breakpoint();
    send_cmd(OP_CLEAR);
    bp_wr = 1; bp_idx = 1'b0; bp_addr = 10'h005; bp_en = 1;
    tick();
    bp_wr = 0;
    pc_if = 10'h000;
    send_cmd(OP_RUN);
    for (int c = 0; c < 5; c++) begin
      pc_if = 10'(c);
      #2;
      n_checks++; if (pipe_enable !== 1'b1) $display("FAIL bp_approach: pc %0h got pe=%b expected 1", pc_if, pipe_enable); else n_pass++;
      tick();
    end
    pc_if = 10'h005;
    #2;
    n_checks++; if (pipe_enable !== 1'b0 || pc_write !== 1'b0) $display("FAIL bp_freeze: got pe=%b pcw=%b expected 0 0", pipe_enable, pc_write); else n_pass++;
    tick();
    #1;
    n_checks++; if (run_state !== 3'(ST_IDLE) || bp_hit !== 2'b01) $display("FAIL bp_stop: got state=%0d hit=%b expected %0d 01", run_state, bp_hit, ST_IDLE); else n_pass++;
    send_cmd(OP_RUN);
    #2;
    n_checks++; if (pipe_enable !== 1'b1 || pc_write !== 1'b1) $display("FAIL bp_resume: got pe=%b pcw=%b expected 1 1", pipe_enable, pc_write); else n_pass++;
    tick();
    pc_if = 10'h006; bp_wr = 1; bp_idx = 1'b1; bp_addr = 10'h006; bp_en = 1;
    #2;
    n_checks++; if (pipe_enable !== 1'b1) $display("FAIL bp_wr_same_cycle: got pe=%b expected 1", pipe_enable); else n_pass++;
    tick();
    bp_wr = 0; pc_if = 10'h007;
    #2;
    n_checks++; if (pipe_enable !== 1'b1 || bp_hit !== 2'b01) $display("FAIL bp_no_rehit: got pe=%b hit=%b expected 1 01", pipe_enable, bp_hit); else n_pass++;
    pc_if = 10'h006;
    #1;
    n_checks++; if (pipe_enable !== 1'b0) $display("FAIL bp_slot1_freeze: got pe=%b expected 0", pipe_enable); else n_pass++;
    tick();
    #1;
    n_checks++; if (bp_hit !== 2'b11 || cycle_count !== 4'(m_count)) $display("FAIL bp_hits_count: got hit=%b cnt=%0d expected 11 %0d", bp_hit, cycle_count, m_count); else n_pass++;
  endtask

  task automatic test_simultaneous();
    send_cmd(OP_CLEAR);
    pc_if = 10'h000;
    send_cmd(OP_RUN);
    tick();
    pc_if = 10'h005; cmd_valid = 1; cmd_op = OP_STOP;
    #2;
    n_checks++; if (pipe_enable !== 1'b0) $display("FAIL bp_stop_pe: got %b expected 0", pipe_enable); else n_pass++;
    tick();
    cmd_valid = 0;
    #1;
    n_checks++; if (run_state !== 3'(ST_IDLE) || bp_hit !== 2'b01) $display("FAIL bp_stop_hit: got state=%0d hit=%b expected %0d 01", run_state, bp_hit, ST_IDLE); else n_pass++;
    send_cmd(OP_RUN);
    tick();
    pc_if = 10'h006; halt_id = 1;
    #2;
    n_checks++; if (pipe_enable !== 1'b0 || ctrl_bubble !== 1'b0) $display("FAIL bp_over_halt: got pe=%b bub=%b expected 0 0", pipe_enable, ctrl_bubble); else n_pass++;
    tick();
    #1;
    n_checks++; if (run_state !== 3'(ST_IDLE) || bp_hit !== 2'b11) $display("FAIL bp_over_halt_state: got state=%0d hit=%b expected %0d 11", run_state, bp_hit, ST_IDLE); else n_pass++;
    send_cmd(OP_RUN);
    #2;
    n_checks++; if (pipe_enable !== 1'b1 || ctrl_bubble !== 1'b1) $display("FAIL halt_reseen: got pe=%b bub=%b expected 1 1", pipe_enable, ctrl_bubble); else n_pass++;
    tick();
    halt_id = 0;
    #1;
    n_checks++; if (run_state !== 3'(ST_DRAIN)) $display("FAIL halt_reseen_drain: got %0d expected %0d", run_state, ST_DRAIN); else n_pass++;
    repeat (3) tick();
    send_cmd(OP_CLEAR);
    #1;
    n_checks++; if (run_state !== 3'(ST_IDLE)) $display("FAIL sim_clear_idle: got %0d expected %0d", run_state, ST_IDLE); else n_pass++;
  endtask

  task automatic test_step();
    pc_if = 10'h3FF;
    send_cmd(OP_CLEAR);
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1; cmd_op = OP_STEP;
      #2;
      n_checks++; if (pipe_enable !== 1'b0 || run_state !== 3'(ST_IDLE)) $display("FAIL step_idle: step %0d got pe=%b state=%0d expected 0 %0d", k, pipe_enable, run_state, ST_IDLE); else n_pass++;
      tick();
      cmd_valid = 0;
      #2;
      n_checks++; if (pipe_enable !== 1'b1 || run_state !== 3'(ST_STEP)) $display("FAIL step_active: step %0d got pe=%b state=%0d expected 1 %0d", k, pipe_enable, run_state, ST_STEP); else n_pass++;
      tick();
    end
    #2;
    n_checks++; if (run_state !== 3'(ST_IDLE) || cycle_count !== 4'd3) $display("FAIL step_done: got state=%0d cnt=%0d expected %0d 3", run_state, cycle_count, ST_IDLE); else n_pass++;
  endtask

  task automatic test_hazard();
    pc_if = 10'h200;
    send_cmd(OP_RUN);
    mem_read_ex = 1; rt_ex = 5'd3; rs_id = 5'd3; rt_id = 5'd7; branch_taken = 1;
    #2;
    n_checks++; if ({pipe_enable, pc_write, if_id_write, ctrl_bubble, if_id_flush} !== 5'b10010) $display("FAIL stall_rs: got %b expected 10010", {pipe_enable, pc_write, if_id_write, ctrl_bubble, if_id_flush}); else n_pass++;
    rt_ex = 5'd0; rs_id = 5'd0;
    #1;
    n_checks++; if ({pc_write, if_id_write, ctrl_bubble, if_id_flush} !== 4'b1101) $display("FAIL no_stall_r0: got %b expected 1101", {pc_write, if_id_write, ctrl_bubble, if_id_flush}); else n_pass++;
    rt_ex = 5'd7; rs_id = 5'd1; branch_taken = 0;
    #1;
    n_checks++; if ({pc_write, if_id_write, ctrl_bubble, if_id_flush} !== 4'b0010) $display("FAIL stall_rt: got %b expected 0010", {pc_write, if_id_write, ctrl_bubble, if_id_flush}); else n_pass++;
    mem_read_ex = 0;
    #1;
    n_checks++; if ({pc_write, ctrl_bubble} !== 2'b10) $display("FAIL no_load: got %b expected 10", {pc_write, ctrl_bubble}); else n_pass++;
    rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    send_cmd(OP_STOP);
  endtask

  task automatic test_halt();
    pc_if = 10'h3FF;
    send_cmd(OP_CLEAR);
    send_cmd(OP_RUN);
    halt_id = 1;
    #2;
    n_checks++; if (pipe_enable !== 1'b1 || ctrl_bubble !== 1'b1) $display("FAIL halt_detect: got pe=%b bub=%b expected 1 1", pipe_enable, ctrl_bubble); else n_pass++;
    tick();
    for (int d = 0; d < 3; d++) begin
      cmd_valid = 1; cmd_op = OP_CLEAR;
      #2;
      n_checks++; if ({run_state, pipe_enable, pc_write, if_id_write, cmd_ready} !== {3'(ST_DRAIN), 4'b1000}) $display("FAIL drain_cycle: %0d got st=%0d pe/pcw/ifw/rdy=%b expected %0d 1000", d, run_state, {pipe_enable, pc_write, if_id_write, cmd_ready}, ST_DRAIN); else n_pass++;
      tick();
    end
    cmd_valid = 0; halt_id = 0;
    #2;
    n_checks++; if (halted !== 1'b1 || pipe_enable !== 1'b0 || cycle_count !== 4'd4) $display("FAIL halted: got h=%b pe=%b cnt=%0d expected 1 0 4", halted, pipe_enable, cycle_count); else n_pass++;
    send_cmd(OP_RUN);
    #1;
    n_checks++; if (run_state !== 3'(ST_HALTED)) $display("FAIL halted_run_ignored: got %0d expected %0d", run_state, ST_HALTED); else n_pass++;
    send_cmd(OP_CLEAR);
    #1;
    n_checks++; if (run_state !== 3'(ST_IDLE) || cycle_count !== 4'd0 || halted !== 1'b0) $display("FAIL halted_clear: got st=%0d cnt=%0d h=%b expected %0d 0 0", run_state, cycle_count, halted, ST_IDLE); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    bp_wr = 1; bp_idx = 1'b0; bp_addr = 10'h010; bp_en = 1;
    tick();
    bp_wr = 0; pc_if = 10'h3FF;
    send_cmd(OP_RUN);
    halt_id = 1;
    tick();
    halt_id = 0;
    tick();
    #2;
    n_checks++; if (run_state !== 3'(ST_DRAIN)) $display("FAIL pre_reset_drain: got %0d expected %0d", run_state, ST_DRAIN); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({run_state, pipe_enable, pc_write, ctrl_bubble, cmd_ready, halted} !== {3'(ST_IDLE), 5'b00010}) $display("FAIL async_reset: got st=%0d pe/pcw/bub/rdy/h=%b expected %0d 00010", run_state, {pipe_enable, pc_write, ctrl_bubble, cmd_ready, halted}, ST_IDLE); else n_pass++;
    n_checks++; if (cycle_count !== 4'd0 || bp_hit !== 2'b00) $display("FAIL async_reset_regs: got cnt=%0d hit=%b expected 0 00", cycle_count, bp_hit); else n_pass++;
    m_reset();
    #1;
    rst = 1'b0;
    tick();
    pc_if = 10'h010;
    send_cmd(OP_RUN);
    tick();
    #2;
    n_checks++; if (pipe_enable !== 1'b1) $display("FAIL bp_disabled_after_reset: got pe=%b expected 1", pipe_enable); else n_pass++;
    send_cmd(OP_STOP);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cmd_valid    = ($urandom_range(0, 3) == 0);
      cmd_op       = 2'($urandom_range(0, 3));
      bp_wr        = ($urandom_range(0, 15) == 0);
      bp_idx       = 1'($urandom_range(0, 1));
      bp_addr      = 10'($urandom_range(0, 7));
      bp_en        = 1'($urandom_range(0, 1));
      pc_if        = 10'($urandom_range(0, 7));
      halt_id      = ($urandom_range(0, 19) == 0);
      branch_taken = 1'($urandom_range(0, 1));
      mem_read_ex  = 1'($urandom_range(0, 1));
      rt_ex        = 5'($urandom_range(0, 3));
      rs_id        = 5'($urandom_range(0, 3));
      rt_id        = 5'($urandom_range(0, 3));
      #2;
      n_checks++; if (run_state !== m_state) $display("FAIL rnd_state: cyc %0d got %0d expected %0d", n, run_state, m_state); else n_pass++;
      n_checks++; if (pipe_enable !== m_pe()) $display("FAIL rnd_pe: cyc %0d got %b expected %b", n, pipe_enable, m_pe()); else n_pass++;
      n_checks++; if (pc_write !== m_pcw() || if_id_write !== m_pcw()) $display("FAIL rnd_write: cyc %0d got %b%b expected %b", n, pc_write, if_id_write, m_pcw()); else n_pass++;
      n_checks++; if (if_id_flush !== m_flush()) $display("FAIL rnd_flush: cyc %0d got %b expected %b", n, if_id_flush, m_flush()); else n_pass++;
      n_checks++; if (cmd_ready !== (m_state != ST_DRAIN)) $display("FAIL rnd_ready: cyc %0d got %b expected %b", n, cmd_ready, m_state != ST_DRAIN); else n_pass++;
      n_checks++; if (halted !== (m_state == ST_HALTED)) $display("FAIL rnd_halted: cyc %0d got %b expected %b", n, halted, m_state == ST_HALTED); else n_pass++;
      n_checks++; if (cycle_count !== 4'(m_count)) $display("FAIL rnd_count: cyc %0d got %0d expected %0d", n, cycle_count, m_count); else n_pass++;
      n_checks++; if (bp_hit !== m_hit) $display("FAIL rnd_hit: cyc %0d got %b expected %b", n, bp_hit, m_hit); else n_pass++;
      if (m_state != ST_DRAIN) begin
        n_checks++; if (ctrl_bubble !== m_bubble()) $display("FAIL rnd_bubble: cyc %0d got %b expected %b", n, ctrl_bubble, m_bubble()); else n_pass++;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_breakpoint();
    test_simultaneous();
    test_step();
    test_hazard();
    test_halt();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
